// File: rtl/vram_pkg.sv
// Shared tile-memory types and widths.
// Used by the memory, the line serializer and the pixel mux.
package vram_pkg;

  localparam int LINE_ADDR_W  = 12;
  localparam int LINE_W       = 256;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_LINE = LINE_W / PIX_W;
  localparam int PIX_IDX_W    = $clog2(PIX_PER_LINE);
  localparam int READ_LATENCY = 1;

  typedef logic [LINE_W-1:0]    tile_line_t;
  typedef logic [PIX_W-1:0]     pix_t;
  typedef logic [PIX_IDX_W-1:0] pix_idx_t;

  typedef enum logic {
    F_IDLE,
    F_WAIT
  } fetch_st_e;

  typedef struct packed {
    tile_line_t line;
    logic       flip;
  } slot_t;

endpackage

// File: rtl/tile_line_mux.sv
// Pixel select from one tile line.
// Flip mirrors the index so pixel 0 becomes the top byte.
module tile_line_mux
  import vram_pkg::*;
(
  input  logic [LINE_W-1:0]    line_i,
  input  logic [PIX_IDX_W-1:0] idx_i,
  input  logic                 flip_i,
  output logic [PIX_W-1:0]     pix_o
);

  pix_t [PIX_PER_LINE-1:0] pixels;
  pix_idx_t                sel;

  assign pixels = line_i;
  // 31-k equals k xor all-ones for a power-of-two count
  assign sel    = idx_i ^ {PIX_IDX_W{flip_i}};
  assign pix_o  = pixels[sel];

endmodule

// File: rtl/tile_line_serializer.sv
// Fetches tile lines and streams them out as pixel indices.
// Active/pending slots let the next line arrive while one drains.
module tile_line_serializer
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = vram_pkg::READ_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LINE_ADDR_W-1:0] req_line,
  input  logic                   req_flip,
  output logic [LINE_ADDR_W-1:0] mem_read_addr,
  input  logic [LINE_W-1:0]      mem_read_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIX_W-1:0]       pix_data,
  output logic                   pix_last,
  output logic                   busy
);

  localparam int LAT_W =
    (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  fetch_st_e st_q, st_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic  fflip_q, fflip_d;
  slot_t act_q, act_d;
  slot_t pend_q, pend_d;
  logic  act_vld_q, act_vld_d;
  logic  pend_vld_q, pend_vld_d;
  pix_idx_t cnt_q, cnt_d;

  logic  req_acc;
  logic  capture;
  logic  pix_hs;
  logic  last_acc;
  logic  act_free;
  logic  cap_to_act;
  slot_t cap_slot;
  pix_t  mux_pix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= F_IDLE;
      lat_q <= '0;
    end else begin
      st_q  <= st_d;
      lat_q <= lat_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
    unique case (st_q)
      F_IDLE: begin
        if (req_acc) begin
          st_d  = F_WAIT;
          lat_d = '0;
        end
      end
      F_WAIT: begin
        if (capture) st_d = F_IDLE;
        else         lat_d = lat_q + 1'b1;
      end
      default: st_d = F_IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset_n && (st_q == F_IDLE) && !pend_vld_q;
    capture   = (st_q == F_WAIT) &&
                (lat_q == LAT_W'(READ_LATENCY));
    busy      = (st_q != F_IDLE) || pend_vld_q || act_vld_q;
  end

  assign req_acc    = req_valid && req_ready;
  assign pix_hs     = pix_valid && pix_ready;
  assign last_acc   = pix_hs && pix_last;
  assign act_free   = !act_vld_q || last_acc;
  assign cap_to_act = capture && act_free && !pend_vld_q;
  assign cap_slot   = '{line: mem_read_data, flip: fflip_q};

  // A fetch only starts with pending empty, so a capture never
  // collides with a pending line; it bypasses to active if free.
  always_comb begin
    addr_d     = addr_q;
    fflip_d    = fflip_q;
    act_d      = act_q;
    act_vld_d  = act_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    if (req_acc) begin
      addr_d  = req_line;
      fflip_d = req_flip;
    end
    if (pix_hs) cnt_d = cnt_q + 1'b1;
    if (act_free) begin
      act_vld_d = pend_vld_q || capture;
      if (pend_vld_q)   act_d = pend_q;
      else if (capture) act_d = cap_slot;
    end
    if (act_free && pend_vld_q) pend_vld_d = 1'b0;
    if (capture && !cap_to_act) begin
      pend_d     = cap_slot;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      fflip_q    <= 1'b0;
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      fflip_q    <= fflip_d;
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  tile_line_mux u_mux (
    .line_i (act_q.line),
    .idx_i  (cnt_q),
    .flip_i (act_q.flip),
    .pix_o  (mux_pix)
  );

  assign mem_read_addr = addr_q;
  assign pix_valid     = act_vld_q;
  assign pix_data      = act_vld_q ? mux_pix : '0;
  assign pix_last      = act_vld_q && (&cnt_q);

endmodule

// File: tb/tb_tile_line_serializer.sv
// Directed bench for tile_line_serializer with a 1-cycle memory.
// Line a holds bytes (a-5)*32+k, so line 5 = 0x00.., line 6 = 0x20..
module tb_tile_line_serializer;
  import vram_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_line = '0;
  logic        req_flip = 1'b0;
  logic [11:0] mem_read_addr;
  logic [255:0] mem_read_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        busy;

  int total = 0;
  int bad = 0;

  tile_line_serializer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_line      (req_line),
    .req_flip      (req_flip),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_last      (pix_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [11:0] a);
    logic [255:0] l;
    int b;
    l = '0;
    for (int k = 0; k < 32; k++) begin
      b = (int'(a) - 5) * 32 + k;
      l[k*8 +: 8] = b[7:0];
    end
    return l;
  endfunction

  always @(posedge clk) mem_read_data <= line_of(mem_read_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int line, input bit flip);
    int n = 0;
    req_line  = 12'(line);
    req_flip  = flip;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_to", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int start, input bit desc,
                        input string tag);
    int e;
    int pos;
    for (int i = 0; i < n; i++) begin
      e   = desc ? start - i : start + i;
      pos = desc ? i : start + i;
      check({tag, "_v"}, 32'(pix_valid), 32'd1);
      check({tag, "_d"}, 32'(pix_data), 32'(e));
      check({tag, "_l"}, 32'(pix_last), 32'((pos % 32) == 31));
      @(negedge clk);
    end
  endtask

  task automatic fetch_check(input int line, input bit flip,
                             input int start, input bit desc,
                             input string tag);
    send(line, flip);
    @(negedge clk);
    check({tag, "_a"}, 32'(mem_read_addr), 32'(line));
    check({tag, "_b"}, 32'(busy), 32'd1);
    check({tag, "_lat0"}, 32'(pix_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat1"}, 32'(pix_valid), 32'd0);
    @(negedge clk);
    stream(32, start, desc, tag);
    check({tag, "_end"}, 32'(pix_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(mem_read_addr), 32'(line));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int hs;
    int c;

    #12;
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_pv", 32'(pix_valid), 32'd0);
    check("rst_pd", 32'(pix_data), 32'd0);
    check("rst_pl", 32'(pix_last), 32'd0);
    check("rst_addr", 32'(mem_read_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel_rdy", 32'(req_ready), 32'd1);
    @(negedge clk);

    fetch_check(5, 1'b0, 0, 1'b0, "fwd");
    fetch_check(5, 1'b1, 31, 1'b1, "flip");

    // back-to-back lines 5 and 6
    send(5, 1'b0);
    fork
      send(6, 1'b0);
      begin
        repeat (3) @(negedge clk);
        stream(12, 0, 1'b0, "b2b");
        check("b2b_rdy", 32'(req_ready), 32'd0);
        stream(52, 12, 1'b0, "b2b");
      end
    join
    check("b2b_end", 32'(pix_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd0);

    // stall pattern 1,0,0,1
    pat = 4'b1001;
    send(5, 1'b0);
    hs = 0;
    c  = 0;
    pix_ready = pat[0];
    while (hs < 32 && c < 200) begin
      @(negedge clk);
      if (pix_valid) begin
        check("stall_d", 32'(pix_data), 32'(hs));
        check("stall_l", 32'(pix_last), 32'(hs == 31));
        if (pix_ready) hs++;
      end
      @(posedge clk);
      #1 c++;
      pix_ready = pat[c % 4];
    end
    pix_ready = 1'b1;
    check("stall_n", 32'(hs), 32'd32);
    @(negedge clk);
    check("stall_end", 32'(pix_valid), 32'd0);

    // reset at pixel 10 of line 5 with line 6 pending
    send(5, 1'b0);
    fork
      send(6, 1'b0);
      begin
        repeat (3) @(negedge clk);
        stream(10, 0, 1'b0, "pre");
      end
    join
    reset_n = 1'b0;
    #1;
    check("mid_pv", 32'(pix_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rdy", 32'(req_ready), 32'd0);
    check("mid_pd", 32'(pix_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("mid_rel", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("mid_idle", 32'(pix_valid), 32'd0);
    fetch_check(6, 1'b0, 32, 1'b0, "l6");

    fetch_check(4095, 1'b0, 64, 1'b0, "l4095");
    fetch_check(5, 1'b0, 0, 1'b0, "again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_line_serializer.md
Name: tile_line_serializer

Overview:
Downstream consumer of vram_tile_memory. Accepts tile-line requests, drives the memory's 12-bit read address, and captures the returned 256-bit line. Serializes each line into 32 8-bit pixel indices on a valid/ready stream toward the sprite compositor. A two-slot line buffer (active + pending) prefetches the next line while the current one shifts out, so back-to-back requests produce no bubbles.

Parameters:
LINE_ADDR_W, 12, width of the tile-line address (matches memory read_addr)
LINE_W, 256, bits per tile line (matches memory read_data)
PIX_W, 8, bits per pixel index; PIX_PER_LINE = LINE_W/PIX_W = 32
READ_LATENCY, 1, clocks from address sampled at posedge to read_data valid

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  line request present
req_ready  out  1  request accepted when req_valid&req_ready at posedge
req_line  in  LINE_ADDR_W  tile-line index to fetch
req_flip  in  1  1 = emit pixels in reverse order (horizontal mirror)
mem_read_addr  out  LINE_ADDR_W  to vram_tile_memory read_addr, registered
mem_read_data  in  LINE_W  from vram_tile_memory read_data
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  PIX_W  pixel index
pix_last  out  1  high with pixel 31 of a line
busy  out  1  any fetch in flight or any slot occupied

Behaviour:
- Reset (async assert, sync-released use): req_ready=0 during reset, 1 the first cycle after; pix_valid=0, pix_data=0, pix_last=0, mem_read_addr=0, busy=0; both slots empty; fetch FSM=IDLE.
- Pixel order: unflipped pixel k = line[8k+7:8k], k=0..31 (pixel 0 = word 0 low byte). Flipped: pixel k = line[8(31-k)+7:8(31-k)].
- Fetch FSM: IDLE -> WAIT on request handshake; mem_read_addr<=req_line at that edge; flip latched. WAIT counts READ_LATENCY cycles after the address is presented, then samples mem_read_data into the pending slot -> IDLE. mem_read_addr holds its value until the next accepted request.
- req_ready = fetch FSM IDLE && pending slot empty. At most one fetch in flight.
- Transfer: pending -> active on the same edge where active is empty, or active's last pixel is accepted (pix_valid&pix_ready&pix_last). Zero-bubble line-to-line streaming.
- Output: pix_valid = active occupied; pix_data/pix_last combinational from active line, counter, and flip; counter 5 bits, increments on handshake, wraps 31->0 at last accept, when active empties unless refilled that edge.
- pix_valid held with stable pix_data/pix_last while pix_ready=0 (no drop, no change).
- Latency: request at edge N -> first pixel valid at edge N+READ_LATENCY+1 when slots empty (N+2 default).
- Simultaneous: request accept and last-pixel accept on the same edge are both legal; pending capture and pending->active transfer on the same edge: transfer sees old pending, new line stored.
- Reset mid-line or mid-fetch: all state cleared immediately; in-flight read discarded.
- busy = FSM!=IDLE || pending occupied || active occupied.

Decomposition:
- Package vram_pkg: LINE_ADDR_W, LINE_W, PIX_W, PIX_PER_LINE constants; typedef tile_line_t (logic[LINE_W-1:0]); typedef pix_t (logic[PIX_W-1:0]); shared with vram_tile_memory.
- One sub-module natural: tile_line_mux (combinational 32:1 pixel select with flip), reused by future palette stage.

Test Plan:
- Preload line 5 with bytes 0x00..0x1F (pixel k = k); request line 5, flip=0, pix_ready=1 -> first pix_valid 2 cycles after accept, pix_data 0x00..0x1F on 32 consecutive cycles, pix_last only on 0x1F.
- Same line, flip=1 -> pix_data 0x1F down to 0x00, pix_last with 0x00.
- Requests line 5 then line 6 (bytes 0x20..0x3F) back to back, pix_ready=1 -> 64 consecutive pixels 0x00..0x3F, no bubble between 0x1F and 0x20; req_ready low while pending full.
- pix_ready toggled 1,0,0,1 pattern on line 5 -> no pixel lost or repeated; pix_data stable during stalls; exactly 32 handshakes.
- Assert reset_n=0 at pixel 10 of line 5 with line 6 pending -> pix_valid=0, busy=0, req_ready=1 after release; new request line 6 streams 0x20 first.
- Request line 4095 -> mem_read_addr=0xFFF held until next accept; returned data serialized correctly.
